// File: rtl/aes_core_arbiter_if.sv
// Requester-side and core-side signals of the shared AES core arbiter.
// slave: the arbiter's view. master: the surrounding system's view.
interface aes_core_arbiter_if #(
  parameter int Nk = 6
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [0:127]      req0_text;
  logic [0:127]      req1_text;
  logic [0:32*Nk-1]  req0_key;
  logic [0:32*Nk-1]  req1_key;
  logic              req0_decrypt;
  logic              req1_decrypt;
  logic              resp0_valid;
  logic              resp1_valid;
  logic              resp0_ready;
  logic              resp1_ready;
  logic [0:127]      resp_data;
  logic [0:127]      core_text;
  logic [0:32*Nk-1]  core_key;
  logic              core_decrypt;
  logic              core_reset;
  logic [0:127]      core_result;
  logic              busy;

  modport slave (
    input  req0_valid, req1_valid, req0_text, req1_text, req0_key, req1_key,
           req0_decrypt, req1_decrypt, resp0_ready, resp1_ready, core_result,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
           core_text, core_key, core_decrypt, core_reset, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_text, req1_text, req0_key, req1_key,
           req0_decrypt, req1_decrypt, resp0_ready, resp1_ready, core_result,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
           core_text, core_key, core_decrypt, core_reset, busy
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// Two-requester round-robin arbiter in front of one shared AES core.
// One job at a time: accept, pulse core restart, wait the core latency,
// capture the result and hold it until the granted requester takes it.
module aes_core_arbiter #(
  parameter int Nk           = 6,
  parameter int Nr           = 12,
  parameter int CORE_LATENCY = 16
) (
  input  logic              clk,
  input  logic              reset,
  aes_core_arbiter_if.slave bus
);

  // Reject illegal configurations at elaboration; Nr itself only travels to the core.
  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_core_arbiter: Nk must be 4, 6 or 8");
  end
  if (Nr < 10 || Nr > 14) begin : g_bad_nr
    $error("aes_core_arbiter: Nr must be in 10..14");
  end
  if (CORE_LATENCY < 1 || CORE_LATENCY > 255) begin : g_bad_lat
    $error("aes_core_arbiter: CORE_LATENCY must be in 1..255");
  end

  // The core first samples core_reset low on the edge that ends the first RUN
  // cycle, so its result is valid CORE_LATENCY edges after that; the capture
  // therefore happens on the edge ending the RUN cycle whose count equals
  // CORE_LATENCY, giving accept-to-response of 2+CORE_LATENCY edges.
  localparam logic [7:0] LAST_CNT = 8'(CORE_LATENCY);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [7:0]        cnt_reg;
  logic              last_grant_reg;
  logic              grant_reg;
  logic [0:127]      text_reg;
  logic [0:32*Nk-1]  key_reg;
  logic              decrypt_reg;
  logic [0:127]      data_reg;

  logic              pick_req1;
  logic              accept0;
  logic              accept1;
  logic              accept;
  logic              resp_take;
  logic              run_last;

  // Round-robin choice: on a tie serve whoever was not served last.
  always_comb begin
    pick_req1 = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) pick_req1 = ~last_grant_reg;
  end

  assign accept0   = (state_reg == IDLE) && bus.req0_valid && !pick_req1;
  assign accept1   = (state_reg == IDLE) && pick_req1;
  assign accept    = accept0 | accept1;
  assign resp_take = (state_reg == DONE) && (grant_reg ? bus.resp1_ready : bus.resp0_ready);
  assign run_last  = (state_reg == RUN) && (cnt_reg == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (run_last) state_next = DONE;
      DONE:    if (resp_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs; core restart is also held while in reset.
  always_comb begin
    bus.req0_ready  = accept0;
    bus.req1_ready  = accept1;
    bus.resp0_valid = (state_reg == DONE) && !grant_reg;
    bus.resp1_valid = (state_reg == DONE) && grant_reg;
    bus.busy        = (state_reg != IDLE);
    bus.core_reset  = !reset || (state_reg == LOAD);
  end

  // Job operands and grant bookkeeping, updated only when a job is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      text_reg       <= '0;
      key_reg        <= '0;
      decrypt_reg    <= 1'b0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      text_reg       <= accept1 ? bus.req1_text    : bus.req0_text;
      key_reg        <= accept1 ? bus.req1_key     : bus.req0_key;
      decrypt_reg    <= accept1 ? bus.req1_decrypt : bus.req0_decrypt;
      grant_reg      <= accept1;
      last_grant_reg <= accept1;
    end
  end

  // Latency counter and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      data_reg <= '0;
    end else begin
      if (state_reg == LOAD)     cnt_reg <= '0;
      else if (state_reg == RUN) cnt_reg <= cnt_reg + 8'd1;
      if (run_last) data_reg <= bus.core_result;
    end
  end

  assign bus.core_text    = text_reg;
  assign bus.core_key     = key_reg;
  assign bus.core_decrypt = decrypt_reg;
  assign bus.resp_data    = data_reg;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: random two-requester traffic against a
// job-level reference model, plus known-answer, stall, mid-job reset and
// single-cycle-latency scenarios.
module tb_aes_core_arbiter;

  localparam int NK     = 6;
  localparam int KW     = 32 * NK;
  localparam int LAT    = 16;
  localparam int LAT1   = 1;
  localparam int N_RAND = 20;
  localparam int N_JOBS = 4 + N_RAND;

  localparam logic [0:KW-1] KEY_V = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [0:127]  PT_V  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127]  CT_V  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  typedef struct packed {
    logic [0:127]  text;
    logic [0:KW-1] key;
    logic          dec;
    logic [0:127]  exp;
  } job_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_core_arbiter_if #(.Nk(NK)) bus ();
  aes_core_arbiter_if #(.Nk(NK)) bus1 ();

  aes_core_arbiter #(.Nk(NK), .Nr(12), .CORE_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  aes_core_arbiter #(.Nk(NK), .Nr(12), .CORE_LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stand-in for the AES core: known-answer pair for the reference vector,
  // an arbitrary keyed mix for everything else.
  function automatic logic [0:127] core_fn(input logic [0:127] t, input logic [0:KW-1] k, input logic d);
    logic [0:127] mix;
    if (k == KEY_V && !d && t == PT_V) return CT_V;
    if (k == KEY_V && d && t == CT_V)  return PT_V;
    mix = {t[64:127], t[0:63]} ^ k[0:127] ^ {128{d}};
    return mix;
  endfunction

  function automatic job_t mk_job(input logic [0:127] t, input logic [0:KW-1] k, input logic d,
                                  input logic [0:127] e);
    job_t j;
    j.text = t; j.key = k; j.dec = d; j.exp = e;
    return j;
  endfunction

  function automatic job_t rand_job();
    logic [0:127]  t;
    logic [0:KW-1] k;
    logic          d;
    t = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d = 1'($urandom_range(0, 1));
    return mk_job(t, k, d, core_fn(t, k, d));
  endfunction

  // Core behaviour: result valid once the core has run LAT edges out of restart.
  int unsigned  edge_cnt  = 0;
  int unsigned  core_age  = 0;
  int unsigned  core1_age = 0;
  logic [0:127] noise     = '0;

  always @(posedge clk) begin
    edge_cnt  <= edge_cnt + 1;
    noise     <= {$urandom, $urandom, $urandom, $urandom};
    core_age  <= bus.core_reset  ? 0 : (core_age  < 1000 ? core_age  + 1 : core_age);
    core1_age <= bus1.core_reset ? 0 : (core1_age < 1000 ? core1_age + 1 : core1_age);
  end

  assign bus.core_result  = (core_age  >= LAT)  ? core_fn(bus.core_text,  bus.core_key,  bus.core_decrypt)  : noise;
  assign bus1.core_result = (core1_age >= LAT1) ? core_fn(bus1.core_text, bus1.core_key, bus1.core_decrypt) : noise;

  // Reference model: pending jobs per requester, one job in flight.
  job_t        q0[$];
  job_t        q1[$];
  int          obs_log[$];
  bit          m_busy;
  bit          m_owner;
  bit          m_last;
  int unsigned m_acc;
  job_t        m_job;
  int          n_acc;
  int          n_done;
  bit          force_both;
  int          stall_left;
  bit          rst_done;

  task automatic drive();
    bit resp_due;
    if (q0.size() > 0) begin
      if (!bus.req0_valid) bus.req0_valid = force_both || ($urandom_range(0, 2) == 0);
    end else begin
      bus.req0_valid = 1'b0;
    end
    if (q1.size() > 0) begin
      if (!bus.req1_valid) bus.req1_valid = force_both || ($urandom_range(0, 2) == 0);
    end else begin
      bus.req1_valid = 1'b0;
    end
    if (bus.req0_valid) begin
      bus.req0_text = q0[0].text; bus.req0_key = q0[0].key; bus.req0_decrypt = q0[0].dec;
    end else begin
      bus.req0_text    = {$urandom, $urandom, $urandom, $urandom};
      bus.req0_key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.req0_decrypt = 1'($urandom_range(0, 1));
    end
    if (bus.req1_valid) begin
      bus.req1_text = q1[0].text; bus.req1_key = q1[0].key; bus.req1_decrypt = q1[0].dec;
    end else begin
      bus.req1_text    = {$urandom, $urandom, $urandom, $urandom};
      bus.req1_key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.req1_decrypt = 1'($urandom_range(0, 1));
    end
    resp_due = m_busy && (edge_cnt >= m_acc + 2 + LAT);
    if (stall_left > 0 && resp_due) begin
      bus.resp0_ready = 1'b0;
      bus.resp1_ready = 1'b0;
      stall_left--;
    end else begin
      bus.resp0_ready = ($urandom_range(0, 3) != 0);
      bus.resp1_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Compare the DUT against the model, then advance the model over the next edge.
  task automatic step_check();
    bit v0, v1, e0, e1, due;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!m_busy) begin
      if (v0 && v1) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    due = m_busy && (edge_cnt >= m_acc + 2 + LAT);
    check_val("req0_ready", bus.req0_ready, e0);
    check_val("req1_ready", bus.req1_ready, e1);
    check_val("busy", bus.busy, m_busy);
    check_val("resp0_valid", bus.resp0_valid, due && !m_owner);
    check_val("resp1_valid", bus.resp1_valid, due && m_owner);
    if (due) check_val("resp_data", bus.resp_data, m_job.exp);
    check_val("core_reset", bus.core_reset, m_busy && (edge_cnt == m_acc));
    check_val("core_text", bus.core_text, m_job.text);
    check_val("core_key", bus.core_key, m_job.key);
    check_val("core_decrypt", bus.core_decrypt, m_job.dec);
    if (bus.req0_valid && bus.req0_ready)      obs_log.push_back(0);
    else if (bus.req1_valid && bus.req1_ready) obs_log.push_back(1);
    if (due && (m_owner ? bus.resp1_ready : bus.resp0_ready)) begin
      m_busy = 1'b0;
      n_done++;
    end else if (e0 || e1) begin
      m_busy  = 1'b1;
      m_owner = e1;
      m_last  = e1;
      m_acc   = edge_cnt + 1;
      m_job   = e1 ? q1.pop_front() : q0.pop_front();
      n_acc++;
      if (n_acc == 4) force_both = 1'b0;
    end
  endtask

  // Reset in the middle of a job: the job is lost and its owner offers it again.
  task automatic mid_run_reset();
    reset = 1'b0;
    #1;
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_core_reset", bus.core_reset, 1'b1);
    check_val("rst_resp_valid", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
    check_val("rst_resp_data", bus.resp_data, 128'h0);
    check_val("rst_core_text", bus.core_text, 128'h0);
    if (m_owner) q1.push_front(m_job);
    else         q0.push_front(m_job);
    m_busy = 1'b0;
    m_last = 1'b1;
    m_job  = mk_job('0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("post_rst_core_reset", bus.core_reset, 1'b0);
    check_val("post_rst_busy", bus.busy, 1'b0);
    drive();
  endtask

  initial begin
    job_t j1;
    int   cyc;
    int   g;

    reset = 1'b1;
    bus.req0_valid = 1'b0;  bus.req1_valid = 1'b0;
    bus.req0_text = '0;     bus.req1_text = '0;
    bus.req0_key = '0;      bus.req1_key = '0;
    bus.req0_decrypt = 1'b0; bus.req1_decrypt = 1'b0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
    bus1.req0_text = '0;    bus1.req1_text = '0;
    bus1.req0_key = '0;     bus1.req1_key = '0;
    bus1.req0_decrypt = 1'b0; bus1.req1_decrypt = 1'b0;
    bus1.resp0_ready = 1'b0; bus1.resp1_ready = 1'b0;
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_acc = 0;
    m_job = mk_job('0, '0, 1'b0, '0);
    n_acc = 0; n_done = 0; force_both = 1'b1; stall_left = 10; rst_done = 1'b0;

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_busy", bus.busy, 1'b0);
    check_val("reset_core_reset", bus.core_reset, 1'b1);
    check_val("reset_resp_valid", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
    check_val("reset_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    check_val("reset_resp_data", bus.resp_data, 128'h0);
    check_val("reset_core_text", bus.core_text, 128'h0);
    check_val("reset_core_key", bus.core_key, 192'h0);
    check_val("reset_core_decrypt", bus.core_decrypt, 1'b0);
    reset = 1'b1;
    #1 check_val("release_core_reset", bus.core_reset, 1'b0);

    // Known-answer pair first, both requesters busy for the first four jobs.
    q0.push_back(mk_job(PT_V, KEY_V, 1'b0, CT_V));
    q1.push_back(mk_job(CT_V, KEY_V, 1'b1, PT_V));
    q0.push_back(rand_job());
    q1.push_back(rand_job());
    for (int i = 0; i < N_RAND; i++) begin
      if ($urandom_range(0, 1) == 1) q0.push_back(rand_job());
      else                           q1.push_back(rand_job());
    end

    @(posedge clk);
    #1 drive();
    cyc = 0;
    while (n_done < N_JOBS && cyc < 20000) begin
      @(negedge clk);
      step_check();
      cyc++;
      if (!rst_done && n_acc == 8 && m_busy && edge_cnt == m_acc + 5) begin
        rst_done = 1'b1;
        mid_run_reset();
      end else begin
        @(posedge clk);
        #1 drive();
      end
    end
    check_val("jobs_done", n_done, N_JOBS);
    check_val("reset_test_ran", rst_done, 1'b1);
    for (int i = 0; i < 4; i++) begin
      g = (obs_log.size() > i) ? obs_log[i] : 9;
      check_val("grant_order", g, i % 2);
    end

    // Single-cycle core latency instance.
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    j1 = rand_job();
    bus1.resp0_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.req0_valid = 1'b1;
    bus1.req0_text = j1.text; bus1.req0_key = j1.key; bus1.req0_decrypt = j1.dec;
    @(negedge clk);
    check_val("l1_accept", bus1.req0_ready, 1'b1);
    @(posedge clk);
    #1 bus1.req0_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("l1_core_reset", bus1.core_reset, k == 0);
      check_val("l1_resp0_valid", bus1.resp0_valid, k == 3);
      check_val("l1_resp1_valid", bus1.resp1_valid, 1'b0);
      check_val("l1_busy", bus1.busy, k < 4);
      if (k == 3) check_val("l1_resp_data", bus1.resp_data, j1.exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
